// File: rtl/alu_wb_stage.sv
// ---------------------------------------------------------------------------
// alu_wb_stage
//   Writeback / result-capture stage after the ALU and fp_unit.
//   - Registers ALUOut together with the destination register index.
//   - Steers the result to the integer or the FP register file.
//   - Stalls the core while a multi-cycle FP op (FADD/FSUB/FMUL) waits for
//     fp_res_vld.
//   - Accumulates the RISC-V accrued FP flags {NV,DZ,OF,UF,NX}.
//
// Optional feature macro: ALU_WB_TIMEOUT_EN
//   When defined, an FP op that waits MAX_WAIT cycles in FP_WAIT without a
//   result is retired with a canonical quiet NaN. NV is set and wb_timeout
//   pulses. Without the macro the wait is unbounded and wb_timeout is tied 0.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   ex_valid          ALU holds a valid instruction this cycle
//   ex_aluctl[4:0]    ALUCtl of that instruction
//   ex_rd[4:0]        destination register index
//   ex_reg_write      instruction writes a register
//   ex_fp_dest        1 = FP regfile, 0 = integer regfile
//   alu_out           ALUOut
//   fp_res_vld        fp_unit result valid
//   fp_overflow/fp_underflow/fp_exception   fp_unit status
//   fflags_clr        clear accrued flags (CSR write)
//   stall             hold PC/pipeline (combinational)
//   wb_valid          one-cycle writeback pulse
//   wb_rd, wb_data    registered destination / result (held when idle)
//   wb_we_int/wb_we_fp  regfile write enables, gated by wb_valid
//   fflags            accrued flags, DZ and NX always 0
//   wb_timeout        one-cycle pulse on FP wait timeout
// ---------------------------------------------------------------------------
module alu_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_aluctl,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_fp_dest,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              fp_res_vld,
    input  logic              fp_overflow,
    input  logic              fp_underflow,
    input  logic              fp_exception,
    input  logic              fflags_clr,
    output logic              stall,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we_int,
    output logic              wb_we_fp,
    output logic [4:0]        fflags,
    output logic              wb_timeout
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_FP_WAIT = 1'b1;

    // Canonical quiet NaN retired when an FP op times out.
    localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

    logic [0:0] state, state_nxt;
    logic       is_multi;
    logic       capture;    // normal writeback of alu_out at the next edge
    logic       tmo_fire;   // timeout writeback at the next edge
    logic       wb_fire;
    logic       tmo_hit;
    logic [4:0] new_flags;

`ifdef ALU_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_incl;

    // wait_cnt holds the FP_WAIT cycles already completed; adding one
    // includes the current cycle, so the MAX_WAIT-th FP_WAIT cycle is the
    // one that retires the op instead of stalling.
    assign wait_cnt_incl = wait_cnt + CNT_W'(1);
    assign tmo_hit       = (state == S_FP_WAIT) && (wait_cnt_incl == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state_nxt != S_FP_WAIT)
            wait_cnt <= '0;
        else if (state == S_FP_WAIT)
            wait_cnt <= wait_cnt + CNT_W'(1);
        else
            wait_cnt <= '0;   // entry cycle: start from zero
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        is_multi  = ex_aluctl inside {5'b10000, 5'b10001, 5'b10010};
        state_nxt = state;
        capture   = 1'b0;
        tmo_fire  = 1'b0;
        stall     = 1'b0;

        case (state)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!is_multi || fp_res_vld) begin
                        capture = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = S_FP_WAIT;
                    end
                end
            end
            S_FP_WAIT: begin
                if (!ex_valid) begin
                    // Flush: abandon the op, nothing is written.
                    state_nxt = S_IDLE;
                end else if (fp_res_vld) begin
                    capture   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // stall must drop immediately while reset is asserted, even though
        // the instruction inputs may still look like a waiting FP op.
        if (rst)
            stall = 1'b0;

        wb_fire = capture | tmo_fire;

        new_flags = 5'b00000;
        if (capture && ex_aluctl[4])
            new_flags = {fp_exception, 1'b0, fp_overflow, fp_underflow, 1'b0};
        else if (tmo_fire)
            new_flags = 5'b10000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_we_int  <= 1'b0;
            wb_we_fp   <= 1'b0;
            fflags     <= '0;
            wb_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            wb_valid   <= wb_fire;
            wb_we_int  <= wb_fire & ex_reg_write & ~ex_fp_dest;
            wb_we_fp   <= wb_fire & ex_reg_write &  ex_fp_dest;
            wb_timeout <= tmo_fire;
            if (wb_fire) begin
                wb_rd   <= ex_rd;
                wb_data <= tmo_fire ? QNAN : alu_out;
            end
            // A clear and a new flag in the same cycle: the new flag survives.
            fflags <= (fflags_clr ? 5'b00000 : fflags) | new_flags;
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_aluctl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_fp_dest;
    logic [31:0] alu_out;
    logic        fp_res_vld;
    logic        fp_overflow;
    logic        fp_underflow;
    logic        fp_exception;
    logic        fflags_clr;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we_int;
    logic        wb_we_fp;
    logic [4:0]  fflags;
    logic        wb_timeout;

    alu_wb_stage #(.DATA_W(32), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_aluctl    (ex_aluctl),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_fp_dest   (ex_fp_dest),
        .alu_out      (alu_out),
        .fp_res_vld   (fp_res_vld),
        .fp_overflow  (fp_overflow),
        .fp_underflow (fp_underflow),
        .fp_exception (fp_exception),
        .fflags_clr   (fflags_clr),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_we_int    (wb_we_int),
        .wb_we_fp     (wb_we_fp),
        .fflags       (fflags),
        .wb_timeout   (wb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we_int;
        logic        we_fp;
        logic [4:0]  ff;
        logic        tmo;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] ctl, input logic [4:0] rd,
                         input logic rw, input logic fpd, input logic [31:0] d,
                         input logic vld);
        ex_valid     = v;
        ex_aluctl    = ctl;
        ex_rd        = rd;
        ex_reg_write = rw;
        ex_fp_dest   = fpd;
        alu_out      = d;
        fp_res_vld   = vld;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic wi,
                        input logic wf, input logic [4:0] ff, input logic tmo);
        sbq.push_back('{rd: rd, data: d, we_int: wi, we_fp: wf, ff: ff, tmo: tmo});
    endtask

    // Monitor: every writeback pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            exp_t a;
            exp_t e;
            a = '{rd: wb_rd, data: wb_data, we_int: wb_we_int, we_fp: wb_we_fp,
                  ff: fflags, tmo: wb_timeout};
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_wb: got rd=%0d data=0x%0h, expected no writeback",
                         wb_rd, wb_data);
            end else begin
                e = sbq.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL wb_rd%0d: got rd=%0d data=0x%0h wi=%b wf=%b ff=%b tmo=%b, expected rd=%0d data=0x%0h wi=%b wf=%b ff=%b tmo=%b",
                             e.rd, a.rd, a.data, a.we_int, a.we_fp, a.ff, a.tmo,
                             e.rd, e.data, e.we_int, e.we_fp, e.ff, e.tmo);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        fp_overflow  = 1'b0;
        fp_underflow = 1'b0;
        fp_exception = 1'b0;
        fflags_clr   = 1'b0;
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fflags", fflags, 0);
        chk("rst_wb_data", wb_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // ADD rd=5, integer destination, latency 1
        drive(1, 5'b00000, 5'd5, 1, 0, 32'h12, 0);
        #1 chk("add_stall", stall, 0);
        push(5'd5, 32'h12, 1, 0, 5'b00000, 0);
        tick();
        // back-to-back: no register write
        drive(1, 5'b00001, 5'd7, 0, 0, 32'hDEADBEEF, 0);
        #1 chk("nowr_stall", stall, 0);
        push(5'd7, 32'hDEADBEEF, 0, 0, 5'b00000, 0);
        tick();
        // FNEG is single-cycle
        drive(1, 5'b10100, 5'd9, 1, 1, 32'h80000001, 0);
        #1 chk("fneg_stall", stall, 0);
        push(5'd9, 32'h80000001, 0, 1, 5'b00000, 0);
        tick();
        // FDIV is single-cycle even without fp_res_vld
        drive(1, 5'b10011, 5'd10, 1, 1, 32'h3F000000, 0);
        #1 chk("fdiv_stall", stall, 0);
        push(5'd10, 32'h3F000000, 0, 1, 5'b00000, 0);
        tick();
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        tick();

        // FMUL rd=3: result 3 cycles after issue
        drive(1, 5'b10010, 5'd3, 1, 1, 32'h11111111, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("fmul_stall%0d", i), stall, 1);
            tick();
        end
        fp_res_vld = 1'b1;
        alu_out    = 32'h40C00000;
        #1 chk("fmul_vld_stall", stall, 0);
        push(5'd3, 32'h40C00000, 0, 1, 5'b00000, 0);
        tick();
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        tick();

        // FADD with result in the issue cycle, underflow
        drive(1, 5'b10000, 5'd4, 1, 1, 32'h3F800000, 1);
        fp_underflow = 1'b1;
        #1 chk("fadd_fast_stall", stall, 0);
        push(5'd4, 32'h3F800000, 0, 1, 5'b00010, 0);
        tick();
        fp_underflow = 1'b0;
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        tick();

        // FADD, overflow arrives together with fflags_clr: set wins, UF cleared
        drive(1, 5'b10000, 5'd6, 1, 1, 32'h0, 0);
        #1 chk("fadd_ovf_stall", stall, 1);
        tick();
        fp_res_vld  = 1'b1;
        fp_overflow = 1'b1;
        fflags_clr  = 1'b1;
        alu_out     = 32'h7F7FFFFF;
        #1 chk("fadd_ovf_vld_stall", stall, 0);
        push(5'd6, 32'h7F7FFFFF, 0, 1, 5'b00100, 0);
        tick();
        fp_overflow = 1'b0;
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        chk("ff_after_clr_set", fflags, 5'b00100);
        tick();
        fflags_clr = 1'b0;
        chk("ff_after_clr", fflags, 0);

        // FSUB flushed in its second FP_WAIT cycle
        drive(1, 5'b10001, 5'd8, 1, 1, 32'hAAAA5555, 0);
        #1 chk("fsub_issue_stall", stall, 1);
        tick();
        #1 chk("fsub_wait_stall", stall, 1);
        tick();
        ex_valid = 1'b0;
        #1 chk("fsub_flush_stall", stall, 0);
        tick();
        // single-cycle op must retire at once: proves IDLE after the flush
        drive(1, 5'b00000, 5'd2, 1, 0, 32'h55, 0);
        #1 chk("post_flush_stall", stall, 0);
        push(5'd2, 32'h55, 1, 0, 5'b00000, 0);
        tick();
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        tick();

`ifdef ALU_WB_TIMEOUT_EN
        // FADD never completes: 4 stall cycles, then NaN with NV and timeout
        drive(1, 5'b10000, 5'd12, 1, 1, 32'h1234, 0);
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("tmo_stall%0d", i), stall, 1);
            tick();
        end
        #1 chk("tmo_release_stall", stall, 0);
        push(5'd12, 32'h7FC00000, 0, 1, 5'b10000, 1);
        tick();
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        tick();
        chk("tmo_pulse_end", wb_timeout, 0);
`endif

        // FDIV with invalid sets NV
        drive(1, 5'b10011, 5'd13, 1, 1, 32'h7FC00000, 0);
        fp_exception = 1'b1;
        push(5'd13, 32'h7FC00000, 0, 1, 5'b10000, 0);
        tick();
        fp_exception = 1'b0;
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);
        tick();
        chk("nv_set", fflags, 5'b10000);

        // reset in the middle of FP_WAIT
        drive(1, 5'b10010, 5'd14, 1, 1, 32'h0, 0);
        tick();
        #1 chk("midwait_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_stall", stall, 0);
        chk("async_rst_wb_valid", wb_valid, 0);
        chk("async_rst_fflags", fflags, 0);
        tick();
        drive(1, 5'b00000, 5'd1, 1, 0, 32'h99, 0);
        rst = 1'b0;
        #1 chk("post_rst_stall", stall, 0);
        push(5'd1, 32'h99, 1, 0, 5'b00000, 0);
        tick();
        drive(0, 5'b00000, 5'd0, 0, 0, 32'h0, 0);

        repeat (3) tick();
        chk("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
